// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the 2:1 AXI-lite arbiter.
// Grant-state encoding and AXI response codes.
package axi_lite_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbM0   = 2'd1,
      ArbM1   = 2'd2
   } arb_state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/axi_lite_rr_grant.sv
// Two-requester round-robin grant FSM. The grant is held until the release pulse,
// then the pointer moves to the other requester.
module axi_lite_rr_grant
   import axi_lite_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       rel,
   output arb_state_e state,
   output logic       rr_ptr
);

   arb_state_e state_q, state_d;
   logic       rr_ptr_q, rr_ptr_d;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         ArbIdle: begin
            // On a tie the pointer picks; otherwise whoever is asking wins.
            if (req[0] && (!req[1] || !rr_ptr_q)) begin
               state_d = ArbM0;
            end else if (req[1]) begin
               state_d = ArbM1;
            end
         end
         ArbM0: begin
            if (rel) begin
               state_d  = ArbIdle;
               rr_ptr_d = 1'b1;
            end
         end
         ArbM1: begin
            if (rel) begin
               state_d  = ArbIdle;
               rr_ptr_d = 1'b0;
            end
         end
         default: state_d = ArbIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ArbIdle;
         rr_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign state  = state_q;
   assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/axi_lite_arbiter.sv
// 2-master to 1-slave AXI-lite arbiter (m0 = IFU, m1 = LSU) with independent
// round-robin read and write paths, one outstanding transaction per path.
module axi_lite_arbiter
   import axi_lite_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   localparam int unsigned STRB_W = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // master 0
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   input  logic [ADDR_W-1:0] m0_awaddr,
   input  logic              m0_awvalid,
   output logic              m0_awready,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   output logic [1:0]        m0_bresp,
   output logic              m0_bvalid,
   input  logic              m0_bready,
   // master 1
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   input  logic [ADDR_W-1:0] m1_awaddr,
   input  logic              m1_awvalid,
   output logic              m1_awready,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   output logic [1:0]        m1_bresp,
   output logic              m1_bvalid,
   input  logic              m1_bready,
   // slave
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready,
   output logic [ADDR_W-1:0] s_awaddr,
   output logic              s_awvalid,
   input  logic              s_awready,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   output logic              s_wvalid,
   input  logic              s_wready,
   input  logic [1:0]        s_bresp,
   input  logic              s_bvalid,
   output logic              s_bready
);

   arb_state_e rd_state, wr_state;
   logic       rd_rr_ptr, wr_rr_ptr;
   logic       rd_m0, rd_m1, wr_m0, wr_m1;
   logic       rd_rel, wr_rel;
   logic       ar_done_q, ar_done_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
   logic       b_ok;

   axi_lite_rr_grant u_rd_grant (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .req    ({m1_arvalid, m0_arvalid}),
      .rel    (rd_rel),
      .state  (rd_state),
      .rr_ptr (rd_rr_ptr)
   );

   axi_lite_rr_grant u_wr_grant (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .req    ({m1_awvalid | m1_wvalid, m0_awvalid | m0_wvalid}),
      .rel    (wr_rel),
      .state  (wr_state),
      .rr_ptr (wr_rr_ptr)
   );

   assign rd_m0 = (rd_state == ArbM0);
   assign rd_m1 = (rd_state == ArbM1);
   assign wr_m0 = (wr_state == ArbM0);
   assign wr_m1 = (wr_state == ArbM1);

   // Read path: address forwarded once, then masked until the R handshake.
   assign s_araddr   = rd_m1 ? m1_araddr : m0_araddr;
   assign s_arvalid  = ((rd_m0 & m0_arvalid) | (rd_m1 & m1_arvalid)) & ~ar_done_q;
   assign m0_arready = rd_m0 & ~ar_done_q & s_arready;
   assign m1_arready = rd_m1 & ~ar_done_q & s_arready;
   assign s_rready   = (rd_m0 & m0_rready) | (rd_m1 & m1_rready);
   assign m0_rvalid  = rd_m0 & s_rvalid;
   assign m1_rvalid  = rd_m1 & s_rvalid;
   assign m0_rdata   = s_rdata;
   assign m1_rdata   = s_rdata;
   assign m0_rresp   = s_rresp;
   assign m1_rresp   = s_rresp;
   assign rd_rel     = s_rvalid & s_rready;

   // Write path: AW and W complete independently; B only once both are done.
   assign b_ok       = aw_done_q & w_done_q;
   assign s_awaddr   = wr_m1 ? m1_awaddr : m0_awaddr;
   assign s_awvalid  = ((wr_m0 & m0_awvalid) | (wr_m1 & m1_awvalid)) & ~aw_done_q;
   assign m0_awready = wr_m0 & ~aw_done_q & s_awready;
   assign m1_awready = wr_m1 & ~aw_done_q & s_awready;
   assign s_wdata    = wr_m1 ? m1_wdata : m0_wdata;
   assign s_wstrb    = wr_m1 ? m1_wstrb : m0_wstrb;
   assign s_wvalid   = ((wr_m0 & m0_wvalid) | (wr_m1 & m1_wvalid)) & ~w_done_q;
   assign m0_wready  = wr_m0 & ~w_done_q & s_wready;
   assign m1_wready  = wr_m1 & ~w_done_q & s_wready;
   assign s_bready   = ((wr_m0 & m0_bready) | (wr_m1 & m1_bready)) & b_ok;
   assign m0_bvalid  = wr_m0 & b_ok & s_bvalid;
   assign m1_bvalid  = wr_m1 & b_ok & s_bvalid;
   assign m0_bresp   = s_bresp;
   assign m1_bresp   = s_bresp;
   assign wr_rel     = s_bvalid & s_bready;

   always_comb begin
      ar_done_d = rd_rel ? 1'b0 : (ar_done_q | (s_arvalid & s_arready));
      aw_done_d = wr_rel ? 1'b0 : (aw_done_q | (s_awvalid & s_awready));
      w_done_d  = wr_rel ? 1'b0 : (w_done_q | (s_wvalid & s_wready));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

`ifndef SYNTHESIS
   ar_addr_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      s_arvalid && !s_arready |=> $stable(s_araddr));
   aw_addr_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      s_awvalid && !s_awready |=> $stable(s_awaddr));
   no_r_in_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      rd_state == ArbIdle |-> !s_rvalid);
   no_b_in_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      wr_state == ArbIdle |-> !s_bvalid);
`endif

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter; the bench itself plays both masters and the slave.
module tb_axi_lite_arbiter;
   import axi_lite_arbiter_pkg::*;

   logic        i_clk, i_rst_n;
   logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
   logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
   logic [1:0]  m0_rresp, m0_bresp;
   logic [3:0]  m0_wstrb;
   logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
   logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic [1:0]  m1_rresp, m1_bresp;
   logic [3:0]  m1_wstrb;
   logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
   logic        s_wvalid, s_wready, s_bvalid, s_bready;
   logic [1:0]  s_rresp, s_bresp;
   logic [3:0]  s_wstrb;
   logic [14:0] out_vec;
   int          checks = 0;
   int          errors = 0;

   axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   assign out_vec = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                     m0_arready, m0_awready, m0_wready, m0_rvalid, m0_bvalid,
                     m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid};

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic zero_inputs();
      m0_araddr = '0; m0_arvalid = 0; m0_rready = 0; m0_awaddr = '0; m0_awvalid = 0;
      m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0; m0_bready = 0;
      m1_araddr = '0; m1_arvalid = 0; m1_rready = 0; m1_awaddr = '0; m1_awvalid = 0;
      m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
      s_arready = 0; s_rdata = '0; s_rresp = RespOkay; s_rvalid = 0;
      s_awready = 0; s_wready = 0; s_bresp = RespOkay; s_bvalid = 0;
   endtask

   task automatic do_reset();
      zero_inputs();
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if (out_vec !== 15'h0) begin
         errors++; $display("FAIL reset_outputs got %b want 0", out_vec);
      end
      checks++;
      if (dut.rd_state !== ArbIdle || dut.wr_state !== ArbIdle
          || dut.rd_rr_ptr !== 1'b0 || dut.wr_rr_ptr !== 1'b0) begin
         errors++; $display("FAIL reset_state rd=%0d wr=%0d ptrs=%b%b want 0 0 00",
                            dut.rd_state, dut.wr_state, dut.rd_rr_ptr, dut.wr_rr_ptr);
      end
   endtask

   task automatic test_single_read();
      m0_araddr = 32'ha000_0000; m0_arvalid = 1; s_arready = 1;
      #1;
      checks++;
      if (s_arvalid !== 1'b0) begin
         errors++; $display("FAIL rd_latency s_arvalid=%b want 0", s_arvalid);
      end
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'ha000_0000) begin
         errors++; $display("FAIL rd_fwd s_arvalid=%b addr=%h want 1 a0000000", s_arvalid, s_araddr);
      end
      checks++;
      if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
         errors++; $display("FAIL rd_ready m0=%b m1=%b want 1 0", m0_arready, m1_arready);
      end
      tick();
      m0_arvalid = 0; m0_rready = 1;
      tick(); tick();
      s_rvalid = 1; s_rdata = 32'h41; s_rresp = RespOkay;
      #1;
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h41 || m0_rresp !== 2'b00 || m1_rvalid !== 1'b0) begin
         errors++; $display("FAIL rd_resp m0_rvalid=%b rdata=%h rresp=%b m1_rvalid=%b want 1 41 00 0",
                            m0_rvalid, m0_rdata, m0_rresp, m1_rvalid);
      end
      tick();
      s_rvalid = 0; m0_rready = 0;
      #1;
      checks++;
      if (dut.rd_state !== ArbIdle || dut.rd_rr_ptr !== 1'b1) begin
         errors++; $display("FAIL rd_release state=%0d ptr=%b want 0 1", dut.rd_state, dut.rd_rr_ptr);
      end
   endtask

   task automatic test_tie();
      s_arready = 1;
      m0_araddr = 32'h1000; m0_arvalid = 1; m1_araddr = 32'h2000; m1_arvalid = 1;
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h1000 || m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
         errors++; $display("FAIL tie_first s_arvalid=%b addr=%h rdy=%b%b want 1 1000 10",
                            s_arvalid, s_araddr, m0_arready, m1_arready);
      end
      tick();
      m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h10; m0_rready = 1;
      #1;
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h10) begin
         errors++; $display("FAIL tie_m0_resp rvalid=%b rdata=%h want 1 10", m0_rvalid, m0_rdata);
      end
      tick();
      s_rvalid = 0; m0_rready = 0; m0_araddr = 32'h3000; m0_arvalid = 1;
      #1;
      checks++;
      if (s_arvalid !== 1'b0 || dut.rd_state !== ArbIdle) begin
         errors++; $display("FAIL tie_gap s_arvalid=%b state=%0d want 0 0", s_arvalid, dut.rd_state);
      end
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h2000 || m0_arready !== 1'b0 || m1_arready !== 1'b1) begin
         errors++; $display("FAIL tie_rr s_arvalid=%b addr=%h rdy=%b%b want 1 2000 01",
                            s_arvalid, s_araddr, m0_arready, m1_arready);
      end
      tick();
      m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h20; m1_rready = 1;
      #1;
      checks++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h20 || m0_rvalid !== 1'b0) begin
         errors++; $display("FAIL tie_m1_resp m1_rvalid=%b rdata=%h m0_rvalid=%b want 1 20 0",
                            m1_rvalid, m1_rdata, m0_rvalid);
      end
      tick();
      s_rvalid = 0; m1_rready = 0;
      #1;
      checks++;
      if (dut.rd_rr_ptr !== 1'b0) begin
         errors++; $display("FAIL tie_ptr_back ptr=%b want 0", dut.rd_rr_ptr);
      end
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000) begin
         errors++; $display("FAIL tie_m0_again s_arvalid=%b addr=%h want 1 3000", s_arvalid, s_araddr);
      end
      tick();
      m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h30; m0_rready = 1;
      tick();
      s_rvalid = 0; m0_rready = 0; s_arready = 0;
   endtask

   task automatic test_write();
      s_awready = 1; s_wready = 1;
      m1_awaddr = 32'ha000_03f8; m1_awvalid = 1;
      #1;
      checks++;
      if (s_awvalid !== 1'b0) begin
         errors++; $display("FAIL wr_latency s_awvalid=%b want 0", s_awvalid);
      end
      tick();
      checks++;
      if (s_awvalid !== 1'b1 || s_awaddr !== 32'ha000_03f8 || m1_awready !== 1'b1
          || m0_awready !== 1'b0) begin
         errors++; $display("FAIL wr_aw s_awvalid=%b addr=%h rdy=%b%b want 1 a00003f8 01",
                            s_awvalid, s_awaddr, m0_awready, m1_awready);
      end
      tick();
      m1_awvalid = 0;
      #1;
      checks++;
      if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin
         errors++; $display("FAIL wr_aw_pulse s_awvalid=%b s_wvalid=%b want 0 0", s_awvalid, s_wvalid);
      end
      tick();
      m1_wdata = 32'h0a; m1_wstrb = 4'h1; m1_wvalid = 1;
      #1;
      checks++;
      if (s_wvalid !== 1'b1 || s_wdata !== 32'h0a || s_wstrb !== 4'h1 || m1_wready !== 1'b1) begin
         errors++; $display("FAIL wr_w s_wvalid=%b data=%h strb=%h m1_wready=%b want 1 0a 1 1",
                            s_wvalid, s_wdata, s_wstrb, m1_wready);
      end
      tick();
      m1_wvalid = 0; s_bvalid = 1; s_bresp = RespOkay; m1_bready = 1;
      #1;
      checks++;
      if (m1_bvalid !== 1'b1 || m0_bvalid !== 1'b0 || s_bready !== 1'b1) begin
         errors++; $display("FAIL wr_b m1_bvalid=%b m0_bvalid=%b s_bready=%b want 1 0 1",
                            m1_bvalid, m0_bvalid, s_bready);
      end
      tick();
      s_bvalid = 0; m1_bready = 0;
      #1;
      checks++;
      if (dut.wr_state !== ArbIdle || dut.aw_done_q !== 1'b0 || dut.w_done_q !== 1'b0) begin
         errors++; $display("FAIL wr_release state=%0d done=%b%b want 0 00",
                            dut.wr_state, dut.aw_done_q, dut.w_done_q);
      end
   endtask

   task automatic test_concurrent();
      s_arready = 1; s_awready = 1; s_wready = 1;
      m0_araddr = 32'h4000; m0_arvalid = 1;
      m1_awaddr = 32'h5000; m1_awvalid = 1; m1_wdata = 32'h55; m1_wstrb = 4'hf; m1_wvalid = 1;
      tick();
      checks++;
      if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b111 || s_araddr !== 32'h4000
          || s_awaddr !== 32'h5000 || s_wdata !== 32'h55) begin
         errors++; $display("FAIL conc_fwd v=%b ar=%h aw=%h w=%h want 111 4000 5000 55",
                            {s_arvalid, s_awvalid, s_wvalid}, s_araddr, s_awaddr, s_wdata);
      end
      tick();
      m0_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
      s_rvalid = 1; s_rdata = 32'h44; m0_rready = 1;
      s_bvalid = 1; s_bresp = RespSlverr; m1_bready = 1;
      #1;
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h44 || m1_bvalid !== 1'b1 || m1_bresp !== 2'b10
          || m0_bvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
         errors++; $display("FAIL conc_resp r=%b %h b=%b %b m0b=%b m1r=%b want 1 44 1 10 0 0",
                            m0_rvalid, m0_rdata, m1_bvalid, m1_bresp, m0_bvalid, m1_rvalid);
      end
      tick();
      s_rvalid = 0; s_bvalid = 0; m0_rready = 0; m1_bready = 0;
      #1;
      checks++;
      if (dut.rd_state !== ArbIdle || dut.wr_state !== ArbIdle) begin
         errors++; $display("FAIL conc_release rd=%0d wr=%0d want 0 0", dut.rd_state, dut.wr_state);
      end
   endtask

   task automatic test_rready_hold();
      s_arready = 1; m0_araddr = 32'h6000; m0_arvalid = 1;
      tick();
      tick();
      m0_arvalid = 0; m1_araddr = 32'h7000; m1_arvalid = 1;
      s_rvalid = 1; s_rdata = 32'h66; m0_rready = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (dut.rd_state !== ArbM0 || s_arvalid !== 1'b0 || m1_arready !== 1'b0
             || m0_rvalid !== 1'b1 || s_rready !== 1'b0) begin
            errors++; $display("FAIL hold_grant[%0d] st=%0d arv=%b m1rdy=%b m0rv=%b srr=%b want 1 0 0 1 0",
                               i, dut.rd_state, s_arvalid, m1_arready, m0_rvalid, s_rready);
         end
         tick();
      end
      m0_rready = 1;
      tick();
      s_rvalid = 0; m0_rready = 0;
      #1;
      checks++;
      if (s_arvalid !== 1'b0 || dut.rd_state !== ArbIdle) begin
         errors++; $display("FAIL hold_idle s_arvalid=%b state=%0d want 0 0", s_arvalid, dut.rd_state);
      end
      tick();
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h7000 || m1_arready !== 1'b1) begin
         errors++; $display("FAIL hold_m1_fwd s_arvalid=%b addr=%h m1_arready=%b want 1 7000 1",
                            s_arvalid, s_araddr, m1_arready);
      end
      tick();
      m1_arvalid = 0; s_rvalid = 1; m1_rready = 1;
      tick();
      s_rvalid = 0; m1_rready = 0; s_arready = 0;
   endtask

   task automatic test_reset_mid_write();
      s_awready = 1; s_wready = 0; m0_awaddr = 32'h8000; m0_awvalid = 1;
      tick();
      tick();
      m0_awvalid = 0; m0_wdata = 32'h88; m0_wvalid = 1; m0_bready = 1;
      #1;
      checks++;
      if (s_wvalid !== 1'b1 || dut.aw_done_q !== 1'b1) begin
         errors++; $display("FAIL midrst_pre s_wvalid=%b aw_done=%b want 1 1", s_wvalid, dut.aw_done_q);
      end
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if (out_vec !== 15'h0) begin
         errors++; $display("FAIL midrst_outputs got %b want 0", out_vec);
      end
      checks++;
      if (dut.wr_state !== ArbIdle || dut.wr_rr_ptr !== 1'b0 || dut.aw_done_q !== 1'b0) begin
         errors++; $display("FAIL midrst_state st=%0d ptr=%b aw_done=%b want 0 0 0",
                            dut.wr_state, dut.wr_rr_ptr, dut.aw_done_q);
      end
      zero_inputs();
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      tick();
      checks++;
      if (dut.wr_state !== ArbIdle || dut.wr_rr_ptr !== 1'b0 || out_vec !== 15'h0) begin
         errors++; $display("FAIL midrst_after st=%0d ptr=%b out=%b want 0 0 0",
                            dut.wr_state, dut.wr_rr_ptr, out_vec);
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_single_read();
      do_reset();
      test_tie();
      test_write();
      test_concurrent();
      test_rready_hold();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
